// File: rtl/ccff_loader.sv
`default_nettype none
// ============================================================================
// ccff_loader -- flushes, length-probes and serially loads a ccff config chain
// Revision: 1.0
// ============================================================================
module ccff_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic                             prog_clk,
  input  logic                             pReset_n,
  input  logic                             start,
  input  logic [WORD_W-1:0]                wr_data,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  output logic                             ccff_head,
  output logic                             ccff_shift_en,
  input  logic                             ccff_tail,
  output logic                             busy,
  output logic                             done,
  output logic                             err_len,
  output logic [$clog2(CHAIN_LEN+1)-1:0]   bits_loaded
);

  localparam int c_cnt_w = $clog2(CHAIN_LEN + 2);
  localparam int c_bl_w  = $clog2(CHAIN_LEN + 1);
  localparam int c_wc_w  = $clog2(WORD_W + 1);

  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_len     = c_cnt_w'(CHAIN_LEN);
  localparam logic [c_cnt_w-1:0] c_len_m1  = c_cnt_w'(CHAIN_LEN - 1);
  localparam logic [c_cnt_w-1:0] c_len_p1  = c_cnt_w'(CHAIN_LEN + 1);
  localparam logic [c_bl_w-1:0]  c_bl_one  = c_bl_w'(1);
  localparam logic [c_bl_w-1:0]  c_bl_len  = c_bl_w'(CHAIN_LEN);
  localparam logic [c_bl_w-1:0]  c_bl_last = c_bl_w'(CHAIN_LEN - 1);
  localparam logic [c_wc_w-1:0]  c_wc_one  = c_wc_w'(1);
  localparam logic [c_wc_w-1:0]  c_wc_last = c_wc_w'(WORD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_PROBE = 3'd2,
    S_LOAD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [WORD_W-1:0]   r_buf;
  logic [c_wc_w-1:0]   r_bcnt;
  logic                r_head;
  logic                r_shift_en;
  logic                r_wr_ready;
  logic                r_done;
  logic                r_err_len;
  logic [c_bl_w-1:0]   r_bits;

  logic                w_accept;
  logic                w_have_bit;
  logic                w_bit;
  logic [WORD_W-1:0]   w_buf_nxt;
  logic [c_wc_w-1:0]   w_bcnt_nxt;
  logic                w_issue;
  logic                w_last_issue;

  // Next payload bit: drain the buffer first, else take the MSB of a word accepted this cycle.
  always_comb begin
    w_accept   = wr_valid && r_wr_ready;
    w_have_bit = 1'b0;
    w_bit      = 1'b0;
    w_buf_nxt  = r_buf;
    w_bcnt_nxt = r_bcnt;
    if (r_bcnt != '0) begin
      w_have_bit = 1'b1;
      w_bit      = r_buf[WORD_W-1];
      w_buf_nxt  = r_buf << 1;
      w_bcnt_nxt = r_bcnt - c_wc_one;
    end else if (w_accept) begin
      w_have_bit = 1'b1;
      w_bit      = wr_data[WORD_W-1];
      w_buf_nxt  = wr_data << 1;
      w_bcnt_nxt = c_wc_last;
    end
  end

  assign w_issue      = w_have_bit && (r_cnt < c_len);
  assign w_last_issue = (r_cnt == c_len_m1);

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_buf      <= '0;
      r_bcnt     <= '0;
      r_head     <= 1'b0;
      r_shift_en <= 1'b0;
      r_wr_ready <= 1'b0;
      r_done     <= 1'b0;
      r_err_len  <= 1'b0;
      r_bits     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_shift_en <= 1'b0;
          r_wr_ready <= 1'b0;
          r_head     <= 1'b0;
          r_bcnt     <= '0;
          if (start) begin
            r_state    <= S_FLUSH;
            r_err_len  <= 1'b0;
            r_bits     <= '0;
            r_cnt      <= '0;
            r_shift_en <= 1'b1;
          end
        end
        S_FLUSH: begin
          if (r_cnt == c_len_m1) begin
            r_state <= S_PROBE;
            r_cnt   <= '0;
            r_head  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        S_PROBE: begin
          // r_cnt is the number of completed probe shifts that ccff_tail currently reflects.
          r_head <= 1'b0;
          if (r_shift_en) r_cnt <= r_cnt + c_cnt_one;
          if ((r_cnt != '0) && ccff_tail) begin
            r_shift_en <= 1'b0;
            if (r_cnt == c_len) begin
              r_state    <= S_LOAD;
              r_cnt      <= '0;
              r_wr_ready <= 1'b1;
            end else begin
              r_state   <= S_IDLE;
              r_err_len <= 1'b1;
              r_done    <= 1'b1;
            end
          end else if (r_cnt == c_len_p1) begin
            r_shift_en <= 1'b0;
            r_state    <= S_IDLE;
            r_err_len  <= 1'b1;
            r_done     <= 1'b1;
          end else if (r_shift_en) begin
            r_shift_en <= (r_cnt < c_len_m1);
          end else begin
            r_shift_en <= (r_cnt == c_len);
          end
        end
        S_LOAD: begin
          if (r_shift_en && (r_bits != c_bl_len)) r_bits <= r_bits + c_bl_one;
          if (r_shift_en && (r_bits == c_bl_last)) begin
            r_state    <= S_DONE;
            r_done     <= 1'b1;
            r_shift_en <= 1'b0;
            r_wr_ready <= 1'b0;
            r_head     <= 1'b0;
            r_bcnt     <= '0;
          end else if (w_issue) begin
            r_head     <= w_bit;
            r_shift_en <= 1'b1;
            r_cnt      <= r_cnt + c_cnt_one;
            if (w_last_issue) begin
              r_bcnt     <= '0;
              r_wr_ready <= 1'b0;
            end else begin
              r_buf      <= w_buf_nxt;
              r_bcnt     <= w_bcnt_nxt;
              r_wr_ready <= (w_bcnt_nxt == '0);
            end
          end else begin
            r_head     <= 1'b0;
            r_shift_en <= 1'b0;
            r_bcnt     <= '0;
            r_wr_ready <= (r_cnt != c_len);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign wr_ready      = r_wr_ready;
  assign ccff_head     = r_head;
  assign ccff_shift_en = r_shift_en;
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign err_len       = r_err_len;
  assign bits_loaded   = r_bits;

endmodule
`default_nettype wire

// File: tb/tb_ccff_loader.sv
`default_nettype none
// Bench for ccff_loader: 4-flop (optionally 3-flop) and 5-flop behavioural chains with a head-bit scoreboard.
module tb_ccff_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, wr_valid, sel, short_chain;
  logic [1:0] wr_data;
  logic       start4, start5, valid4, valid5;
  logic       rdy4, head4, sh4, tail4, busy4, done4, err4;
  logic       rdy5, head5, sh5, tail5, busy5, done5, err5;
  logic [2:0] bl4, bl5;
  logic [3:0] chain4;
  logic [4:0] chain5;
  logic       rdy_s, head_s, shen_s, busy_s, done_s, err_s;
  logic [2:0] bl_s;

  assign start4 = start & ~sel;
  assign start5 = start & sel;
  assign valid4 = wr_valid & ~sel;
  assign valid5 = wr_valid & sel;

  ccff_loader #(.CHAIN_LEN(4), .WORD_W(2)) u_dut4 (
    .prog_clk(clk), .pReset_n(rst_n), .start(start4), .wr_data(wr_data),
    .wr_valid(valid4), .wr_ready(rdy4), .ccff_head(head4), .ccff_shift_en(sh4),
    .ccff_tail(tail4), .busy(busy4), .done(done4), .err_len(err4), .bits_loaded(bl4)
  );

  ccff_loader #(.CHAIN_LEN(5), .WORD_W(2)) u_dut5 (
    .prog_clk(clk), .pReset_n(rst_n), .start(start5), .wr_data(wr_data),
    .wr_valid(valid5), .wr_ready(rdy5), .ccff_head(head5), .ccff_shift_en(sh5),
    .ccff_tail(tail5), .busy(busy5), .done(done5), .err_len(err5), .bits_loaded(bl5)
  );

  // Bit 0 is the head flop, the top bit the tail flop.
  always @(posedge clk) if (sh4) chain4 <= {chain4[2:0], head4};
  always @(posedge clk) if (sh5) chain5 <= {chain5[3:0], head5};
  assign tail4 = short_chain ? chain4[2] : chain4[3];
  assign tail5 = chain5[4];

  assign rdy_s  = sel ? rdy5  : rdy4;
  assign head_s = sel ? head5 : head4;
  assign shen_s = sel ? sh5   : sh4;
  assign busy_s = sel ? busy5 : busy4;
  assign done_s = sel ? done5 : done4;
  assign err_s  = sel ? err5  : err4;
  assign bl_s   = sel ? bl5   : bl4;

  int         n_pass, n_total;
  int         n_done, n_rdy, n_pushed, gap_left, exp_len;
  bit         acc, start_req, gap_pending, sb_on;
  logic       q_exp[$];
  logic [1:0] q_words[$];
  logic [3:0] snap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One cycle: retire last accept into the scoreboard, check this cycle's shift, drive next inputs.
  task automatic step();
    logic [1:0] w;
    int gidx;
    @(negedge clk);
    if (acc) begin
      w = q_words.pop_front();
      for (int i = 1; i >= 0; i--) begin
        if (n_pushed < exp_len) begin
          q_exp.push_back(w[i]);
          n_pushed++;
        end
      end
      if (gap_pending) begin
        gap_left    = 5;
        gap_pending = 0;
      end
    end
    gidx = 0;
    if (gap_left > 0) begin
      gidx = 6 - gap_left;
      gap_left--;
    end
    if (done_s) n_done++;
    if (rdy_s) n_rdy++;
    if (sb_on && shen_s) begin
      if (q_exp.size() == 0) chk("extra_shift", shen_s, 0);
      else chk("head_bit", head_s, q_exp.pop_front());
    end
    if (gidx >= 3) begin
      chk("gap_shift_en", shen_s, 0);
      if (gidx == 3) snap = chain4;
      else chk("gap_chain_hold", chain4, snap);
    end
    start     = start_req;
    start_req = 0;
    wr_valid  = (q_words.size() > 0) && (gidx == 0);
    wr_data   = (q_words.size() > 0) ? q_words[0] : 2'b00;
    acc       = wr_valid && rdy_s;
  endtask

  task automatic begin_seq(input bit pass);
    n_done   = 0;
    n_rdy    = 0;
    n_pushed = 0;
    acc      = 0;
    q_exp.delete();
    q_words.delete();
    if (pass) begin
      for (int i = 0; i < exp_len; i++) q_exp.push_back(1'b0);
      q_exp.push_back(1'b1);
      for (int i = 1; i < exp_len; i++) q_exp.push_back(1'b0);
    end
    sb_on     = pass;
    start_req = 1;
  endtask

  task automatic run(input int budget);
    for (int i = 0; i < budget && n_done == 0; i++) step();
    repeat (3) step();
    chk("done_pulses", n_done, 1);
  endtask

  task automatic pass_results(input string tag);
    chk({tag, "_sb_empty"}, q_exp.size(), 0);
    chk({tag, "_bits_loaded"}, bl_s, exp_len);
    chk({tag, "_err_len"}, err_s, 0);
    chk({tag, "_busy"}, busy_s, 0);
  endtask

  initial begin
    n_pass = 0; n_total = 0; exp_len = 4;
    rst_n = 0; start = 0; wr_valid = 0; wr_data = 2'b00; sel = 0; short_chain = 0;
    acc = 0; start_req = 0; gap_pending = 0; sb_on = 0; gap_left = 0;
    n_done = 0; n_rdy = 0; n_pushed = 0; snap = '0;
    repeat (3) @(negedge clk);
    chk("rst_shift_en", sh4, 0);
    chk("rst_wr_ready", rdy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_err_len", err4, 0);
    chk("rst_bits_loaded", bl4, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_head", head4, 0);
    rst_n = 1;
    step();
    chk("idle_busy", busy_s, 0);

    // Basic load with words held valid.
    begin_seq(1);
    q_words = {2'b10, 2'b11};
    run(80);
    pass_results("basic");
    chk("basic_chain", chain4, 4'b1011);

    // Chain one flop short: probe error, no load.
    short_chain = 1;
    begin_seq(0);
    run(80);
    chk("short_err_len", err_s, 1);
    chk("short_no_wr_ready", n_rdy, 0);
    chk("short_busy", busy_s, 0);
    repeat (3) step();
    chk("short_err_sticky", err_s, 1);
    short_chain = 0;

    // Five idle cycles between words.
    begin_seq(1);
    gap_pending = 1;
    q_words = {2'b10, 2'b11};
    run(100);
    pass_results("gap");
    chk("gap_chain", chain4, 4'b1011);

    // Reset after two load shifts.
    begin_seq(1);
    q_words = {2'b10, 2'b11};
    for (int i = 0; i < 60 && bl_s != 3'd2; i++) step();
    chk("midload_bits", bl_s, 2);
    snap = chain4;
    #2 rst_n = 0;
    #1;
    chk("midrst_shift_en", sh4, 0);
    chk("midrst_busy", busy4, 0);
    chk("midrst_wr_ready", rdy4, 0);
    @(posedge clk);
    #1;
    chk("midrst_chain_hold", chain4, snap);
    @(negedge clk);
    rst_n = 1;
    q_exp.delete();
    q_words.delete();
    acc = 0; wr_valid = 0; start = 0;

    // Full rerun with stray start pulses during probe and load.
    begin_seq(1);
    q_words = {2'b10, 2'b11};
    for (int i = 0; i < 100 && n_done == 0; i++) begin
      if (i == 8 || i == 13) start_req = 1;
      step();
    end
    repeat (3) step();
    chk("rerun_done_pulses", n_done, 1);
    pass_results("rerun");
    chk("rerun_chain", chain4, 4'b1011);

    // Five-flop chain, last word's LSB discarded.
    sel = 1;
    exp_len = 5;
    begin_seq(1);
    q_words = {2'b10, 2'b11, 2'b01};
    run(100);
    pass_results("len5");
    chk("len5_chain", chain5, 5'b10110);
    chk("len5_words_used", q_words.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 64: number of configuration flops in the downstream ccff chain (>=2).
REQ-002 Parameter WORD_W, default 8: bitstream word width (>=1).
REQ-003 prog_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 pReset_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to begin flush/probe/load.
REQ-006 wr_data  in  WORD_W  bitstream word, MSB shifted first.
REQ-007 wr_valid  in  1  wr_data valid.
REQ-008 wr_ready  out  1  loader accepts wr_data this cycle.
REQ-009 ccff_head  out  1  serial data into chain head.
REQ-010 ccff_shift_en  out  1  chain clock enable; chain captures ccff_head on a prog_clk edge only when high.
REQ-011 ccff_tail  in  1  chain tail return.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 err_len  out  1  sticky chain-length mismatch flag.
REQ-015 bits_loaded  out  $clog2(CHAIN_LEN+1)  payload bits shifted in the current or last LOAD.

Function
REQ-016 ccff_head, ccff_shift_en, wr_ready, done SHALL be registered outputs.
REQ-017 FSM states SHALL be IDLE, FLUSH, PROBE, LOAD, DONE.
REQ-018 IDLE: shift_en=0, wr_ready=0; start=1 -> FLUSH, clear err_len and bits_loaded, clear shift counter.
REQ-019 start SHALL be ignored in every state except IDLE.
REQ-020 FLUSH: ccff_head=0, shift_en=1 for exactly CHAIN_LEN consecutive cycles, then PROBE.
REQ-021 PROBE: first shift cycle drives ccff_head=1, later cycles 0, shift_en=1 every cycle; shift count k=1 on the edge capturing the 1.
REQ-022 ccff_tail SHALL be sampled in the cycle following each shift edge.
REQ-023 PROBE passes if ccff_tail first reads 1 after shift k==CHAIN_LEN; -> LOAD.
REQ-024 PROBE fails if tail reads 1 at any k<CHAIN_LEN or is still 0 after k==CHAIN_LEN+1; on failure set err_len=1, pulse done, -> IDLE (no LOAD).
REQ-025 LOAD: wr_ready=1 when the internal word buffer is empty; word accepted on wr_valid&wr_ready.
REQ-026 Each accepted word SHALL be shifted MSB first, one bit per cycle with shift_en=1; shift_en=0 in any cycle with no buffered bit (stall, chain holds).
REQ-027 Back-to-back words SHALL shift with no bubble: the next word may be accepted in the cycle the current word's last bit shifts.
REQ-028 bits_loaded increments by 1 per LOAD shift edge and saturates at CHAIN_LEN.
REQ-029 If CHAIN_LEN is not a multiple of WORD_W, the final word's unused low-order bits SHALL be discarded, not shifted.
REQ-030 When bits_loaded reaches CHAIN_LEN: shift_en=0, wr_ready=0 next cycle, -> DONE.
REQ-031 DONE: done=1 for exactly one cycle, -> IDLE.
REQ-032 The first payload bit shifted SHALL end at the chain tail flop; the last at the head flop.
REQ-033 err_len SHALL hold until the next accepted start.

Reset
REQ-034 pReset_n low SHALL asynchronously force IDLE, ccff_head=0, ccff_shift_en=0, wr_ready=0, done=0, err_len=0, bits_loaded=0, word buffer empty.
REQ-035 Reset asserted mid-FLUSH/PROBE/LOAD SHALL abort with no further shift edge; after release, chain contents are undefined until a new start.
REQ-036 Release of pReset_n SHALL take effect on the next prog_clk edge; no output changes before it.

Verification (CHAIN_LEN=4, WORD_W=2, behavioural 4-flop chain model)
REQ-037 start, words 2'b10, 2'b11 streamed with wr_valid held -> 4 flush + 4 probe shifts, tail 1 at k=4, 4 load shifts, chain holds 1,0,1,1 from tail to head, done one pulse, err_len=0.
REQ-038 Chain model shortened to 3 flops -> tail 1 at k=3, err_len=1, done pulse, no wr_ready ever asserted.
REQ-039 LOAD with wr_valid low 5 cycles between words -> shift_en=0 for those cycles, chain unchanged, final contents identical to REQ-037.
REQ-040 CHAIN_LEN=5, words 2'b10, 2'b11, 2'b01 -> exactly 5 load shifts, last word's LSB discarded, bits_loaded=5.
REQ-041 pReset_n pulsed low after 2 LOAD shifts -> same-cycle shift_en=0, busy=0; subsequent start re-runs full sequence correctly.
REQ-042 start pulsed during PROBE and LOAD -> no effect; single done pulse at end.
